// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the frequency meter.
// Imported by the synchronizer and the gate-window controller.
package freq_meter_pkg;

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus a
// single-cycle rising-edge pulse in the clk domain.
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   fill_q;

    // fill_q masks rise until the chain holds only post-reset samples,
    // so a level already high at reset release is not seen as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & fill_q[SYNC_STAGES];

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over a fixed gate window
// and publishes the result with a one-cycle valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [GW-1:0]    gate_q;
    logic [CNT_W-1:0] edge_q;
    logic [CNT_W-1:0] edge_nx;
    logic             sat_q;
    logic             sat_nx;
    logic             rise;
    logic             last;
    logic             done;
    logic             counting;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sig_in),
        .rise (rise)
    );

    always_comb begin
        state_d  = IDLE;
        edge_nx  = edge_q;
        sat_nx   = sat_q;
        busy     = (state_q == GATE);
        last     = (gate_q == LAST);
        done     = busy && last;
        counting = busy && !last && en;

        if (rise) begin
            if (edge_q == CMAX) begin
                sat_nx = 1'b1;
            end else begin
                edge_nx = edge_q + 1'b1;
            end
        end

        // A terminal cycle always completes; en only decides restart vs idle
        unique case (state_q)
            IDLE: state_d = en ? GATE : IDLE;
            GATE: state_d = en ? GATE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gate_q      <= '0;
            edge_q      <= '0;
            sat_q       <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_valid <= done;
            if (done) begin
                count    <= edge_nx;
                overflow <= sat_nx;
            end
            if (counting) begin
                gate_q <= gate_q + 1'b1;
                edge_q <= edge_nx;
                sat_q  <= sat_nx;
            end else begin
                gate_q <= '0;
                edge_q <= '0;
                sat_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed and randomized bench for freq_meter: two instances with
// 100- and 600-cycle gates against a window-level reference model.
module tb_freq_meter;

    localparam int GA   = 100;
    localparam int GB   = 600;
    localparam int CW   = 8;
    localparam int SYNC = 2;
    localparam int MAXC = 255;
    localparam int HN   = 16384;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sig_in = 1'b0;
    logic          en_a = 1'b0;
    logic          en_b = 1'b0;
    logic [CW-1:0] count_a;
    logic [CW-1:0] count_b;
    logic          valid_a;
    logic          valid_b;
    logic          ovf_a;
    logic          ovf_b;
    logic          busy_a;
    logic          busy_b;

    always #5 clk = ~clk;

    freq_meter #(
        .GATE_CYCLES(GA), .CNT_W(CW), .SYNC_STAGES(SYNC)
    ) dut_a (
        .clk(clk), .reset(reset), .sig_in(sig_in), .en(en_a),
        .count(count_a), .count_valid(valid_a),
        .overflow(ovf_a), .busy(busy_a)
    );

    freq_meter #(
        .GATE_CYCLES(GB), .CNT_W(CW), .SYNC_STAGES(SYNC)
    ) dut_b (
        .clk(clk), .reset(reset), .sig_in(sig_in), .en(en_b),
        .count(count_b), .count_valid(valid_b),
        .overflow(ovf_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rst = 0;
    bit s_hist[HN];

    int mode  = 1;
    bit sig_const = 1'b0;
    int per   = 10;
    int phase = 0;

    // Window-level reference: edges held as plain ints, clamped at publish
    int m_busy[2];
    int m_gate[2];
    int m_edges[2];
    int m_count[2];
    bit m_valid[2];
    bit m_ovf[2];
    int gcyc[2] = '{GA, GB};
    int nvalid[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // A sig_in rise sampled at edge k (0 at k-1, both after reset) is
    // counted by the window cycle that ends at edge k+SYNC.
    function automatic bit model_edge(input int m);
        if (m < SYNC + 1) return 1'b0;
        if (m - SYNC - 1 <= last_rst) return 1'b0;
        return s_hist[(m - SYNC) % HN] && !s_hist[(m - SYNC - 1) % HN];
    endfunction

    task automatic model_step(input int m);
        bit e;
        bit en_i;
        int tot;
        e = model_edge(m);
        if (reset) last_rst = m;
        for (int i = 0; i < 2; i++) begin
            en_i = (i == 0) ? en_a : en_b;
            if (reset) begin
                m_busy[i] = 0; m_gate[i] = 0; m_edges[i] = 0;
                m_count[i] = 0; m_valid[i] = 0; m_ovf[i] = 0;
            end else if (m_busy[i] == 0) begin
                m_valid[i] = 0;
                if (en_i) begin
                    m_busy[i] = 1; m_gate[i] = 0; m_edges[i] = 0;
                end
            end else begin
                tot = m_edges[i] + int'(e);
                if (m_gate[i] == gcyc[i] - 1) begin
                    m_count[i] = (tot > MAXC) ? MAXC : tot;
                    m_ovf[i]   = (tot > MAXC);
                    m_valid[i] = 1;
                    m_gate[i]  = 0;
                    m_edges[i] = 0;
                    m_busy[i]  = int'(en_i);
                end else if (!en_i) begin
                    m_busy[i]  = 0;
                    m_valid[i] = 0;
                end else begin
                    m_gate[i]++;
                    m_edges[i] = tot;
                    m_valid[i] = 0;
                end
            end
        end
    endtask

    task automatic drive_sig();
        case (mode)
            0: sig_in = sig_const;
            1: sig_in = (((cyc + phase) % per) < (per / 2));
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic set_const(input bit v);
        mode = 0;
        sig_const = v;
        sig_in = v;
    endtask

    task automatic tick();
        @(posedge clk);
        s_hist[cyc % HN] = sig_in;
        model_step(cyc);
        cyc++;
        #1;
        chk("count_a", 32'(count_a), 32'(m_count[0]));
        chk("valid_a", 32'(valid_a), 32'(m_valid[0]));
        chk("ovf_a",   32'(ovf_a),   32'(m_ovf[0]));
        chk("busy_a",  32'(busy_a),  32'(m_busy[0]));
        chk("count_b", 32'(count_b), 32'(m_count[1]));
        chk("valid_b", 32'(valid_b), 32'(m_valid[1]));
        chk("ovf_b",   32'(ovf_b),   32'(m_ovf[1]));
        chk("busy_b",  32'(busy_b),  32'(m_busy[1]));
        if (valid_a) nvalid[0]++;
        if (valid_b) nvalid[1]++;
        drive_sig();
    endtask

    task automatic wait_valid(input int i, input int budget, output int el);
        bit seen;
        seen = 1'b0;
        el = 0;
        while (!seen && el < budget) begin
            tick();
            el++;
            seen = (i == 0) ? valid_a : valid_b;
        end
        chk((i == 0) ? "wait_valid_a" : "wait_valid_b", 32'(seen), 32'd1);
    endtask

    int el;
    int nv;
    int guard;

    initial begin
        // 1: reset values, then period-10 input
        phase = $urandom_range(0, 9);
        mode = 1; per = 10;
        repeat (3) tick();
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_ovf",   32'(ovf_a),   32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        reset = 1'b0;
        repeat (8) tick();
        en_a = 1'b1;
        wait_valid(0, 200, el);
        chk("t1_count", 32'(count_a), 32'd10);
        chk("t1_ovf",   32'(ovf_a),   32'd0);
        repeat (2) begin
            wait_valid(0, 200, el);
            chk("t1_gap",   32'(el),      32'(GA));
            chk("t1_count", 32'(count_a), 32'd10);
        end

        // 2: max rate, then saturation on the long gate
        per = 2;
        wait_valid(0, 200, el);
        wait_valid(0, 200, el);
        chk("t2_count50", 32'(count_a), 32'd50);
        en_b = 1'b1;
        wait_valid(1, 700, el);
        chk("t2_sat_count", 32'(count_b), 32'd255);
        chk("t2_sat_ovf",   32'(ovf_b),   32'd1);
        per = 10;
        wait_valid(1, 700, el);
        wait_valid(1, 700, el);
        chk("t2_count60", 32'(count_b), 32'd60);
        chk("t2_ovf_clr", 32'(ovf_b),   32'd0);
        en_b = 1'b0;

        // 3: abort at gate cycle 40
        wait_valid(0, 200, el);
        repeat (40) tick();
        en_a = 1'b0;
        tick();
        chk("t3_busy", 32'(busy_a), 32'd0);
        nv = nvalid[0];
        repeat (150) tick();
        chk("t3_novalid", 32'(nvalid[0]), 32'(nv));
        chk("t3_hold",    32'(count_a),   32'd10);
        en_a = 1'b1;
        wait_valid(0, 300, el);
        chk("t3_latency", 32'(el),      32'(GA + 1));
        chk("t3_count",   32'(count_a), 32'd10);

        // 4: reset at gate cycle 70, release away from a rise
        wait_valid(0, 200, el);
        repeat (70) tick();
        reset = 1'b1;
        tick();
        chk("t4_count", 32'(count_a), 32'd0);
        chk("t4_valid", 32'(valid_a), 32'd0);
        chk("t4_ovf",   32'(ovf_a),   32'd0);
        chk("t4_busy",  32'(busy_a),  32'd0);
        guard = 0;
        while (((cyc - 1 + phase) % per) != 5 && guard < 20) begin
            tick();
            guard++;
        end
        reset = 1'b0;
        wait_valid(0, 300, el);
        chk("t4_count10", 32'(count_a), 32'd10);

        // 5: constant high across reset release
        set_const(1'b1);
        reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        repeat (2) begin
            wait_valid(0, 300, el);
            chk("t5_count", 32'(count_a), 32'd0);
            chk("t5_ovf",   32'(ovf_a),   32'd0);
        end

        // 6: single rises on the terminal cycle and the first cycle
        set_const(1'b0);
        wait_valid(0, 200, el);
        repeat (97) tick();
        set_const(1'b1);
        wait_valid(0, 200, el);
        chk("t6_terminal", 32'(count_a), 32'd1);
        set_const(1'b0);
        repeat (98) tick();
        set_const(1'b1);
        wait_valid(0, 200, el);
        chk("t6_between", 32'(count_a), 32'd0);
        wait_valid(0, 200, el);
        chk("t6_first", 32'(count_a), 32'd1);

        // 7: random input, random en and occasional reset
        mode = 2;
        repeat (1500) begin
            if ($urandom_range(0, 59) == 0) en_a = ~en_a;
            if ($urandom_range(0, 199) == 0) en_b = ~en_b;
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) begin
                mode = 1;
                per = $urandom_range(2, 12);
            end else if ($urandom_range(0, 299) == 0) begin
                mode = 2;
            end
            tick();
        end
        reset = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
